// File: rtl/pyrm_writeback_block_if.sv
// Writeback stage bus: ALU and load result channels in, paired reg_addr/reg_data write stream out.
interface pyrm_writeback_block_if;
  logic [4:0]  alu_dest_pyri;
  logic [63:0] alu_data_pyri;
  logic        alu_valid_pyri;
  logic        alu_retry_pyro;
  logic [4:0]  ld_dest_pyri;
  logic [63:0] ld_data_pyri;
  logic        ld_valid_pyri;
  logic        ld_retry_pyro;
  logic [63:0] reg_addr_pyro;
  logic        reg_addr_valid_pyro;
  logic        reg_addr_retry_pyri;
  logic [63:0] reg_data_pyro;
  logic        reg_data_valid_pyro;
  logic        reg_data_retry_pyri;

  // Environment side: drives results and consumer stalls.
  modport master (
    output alu_dest_pyri, alu_data_pyri, alu_valid_pyri,
    input  alu_retry_pyro,
    output ld_dest_pyri, ld_data_pyri, ld_valid_pyri,
    input  ld_retry_pyro,
    input  reg_addr_pyro, reg_addr_valid_pyro,
    output reg_addr_retry_pyri,
    input  reg_data_pyro, reg_data_valid_pyro,
    output reg_data_retry_pyri
  );

  // Writeback block side.
  modport slave (
    input  alu_dest_pyri, alu_data_pyri, alu_valid_pyri,
    output alu_retry_pyro,
    input  ld_dest_pyri, ld_data_pyri, ld_valid_pyri,
    output ld_retry_pyro,
    output reg_addr_pyro, reg_addr_valid_pyro,
    input  reg_addr_retry_pyri,
    output reg_data_pyro, reg_data_valid_pyro,
    input  reg_data_retry_pyri
  );
endinterface

// File: rtl/pyrm_writeback_block.sv
// Retire/writeback stage: round-robin merge of ALU and load results into an in-order FIFO
// feeding the decode stage's register-file write stream; x0 writes are absorbed here.
module pyrm_writeback_block #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_pyri,
  pyrm_writeback_block_if.slave  wb,
  output logic [CNT_W-1:0]       retire_cnt_pyro,
  output logic                   fifo_full_pyro
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BW = PTR_W + 1;

  logic [4:0]        dest_mem [DEPTH];
  logic [63:0]       data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_BW-1:0] count;
  logic              rr;
  logic [CNT_W-1:0]  retire_cnt;

  logic              out_valid_c;
  logic              pop_c;
  logic              space_c;
  logic              grant_alu_c;
  logic              grant_ld_c;
  logic              push_c;
  logic              rr_next_c;
  logic [4:0]        wr_dest_c;
  logic [63:0]       wr_data_c;

  // Arbitration, retry generation and output presentation.
  always_comb begin
    out_valid_c       = 1'b0;
    pop_c             = 1'b0;
    space_c           = 1'b0;
    grant_alu_c       = 1'b0;
    grant_ld_c        = 1'b0;
    rr_next_c         = rr;
    wb.alu_retry_pyro = 1'b1;
    wb.ld_retry_pyro  = 1'b1;

    out_valid_c = reset_pyri && (count != '0);
    pop_c       = out_valid_c && !wb.reg_addr_retry_pyri && !wb.reg_data_retry_pyri;
    space_c     = (count < CNT_BW'(DEPTH)) || pop_c;

    if (reset_pyri && space_c) begin
      wb.alu_retry_pyro = 1'b0;
      wb.ld_retry_pyro  = 1'b0;
      if (wb.alu_valid_pyri && wb.ld_valid_pyri) begin
        // Contention: rr picks the winner, then priority passes to the loser.
        if (rr) begin
          grant_ld_c        = 1'b1;
          wb.alu_retry_pyro = 1'b1;
          rr_next_c         = 1'b0;
        end else begin
          grant_alu_c       = 1'b1;
          wb.ld_retry_pyro  = 1'b1;
          rr_next_c         = 1'b1;
        end
      end else if (wb.alu_valid_pyri) begin
        grant_alu_c = 1'b1;
      end else if (wb.ld_valid_pyri) begin
        grant_ld_c = 1'b1;
      end
    end

    wr_dest_c = grant_ld_c ? wb.ld_dest_pyri : wb.alu_dest_pyri;
    wr_data_c = grant_ld_c ? wb.ld_data_pyri : wb.alu_data_pyri;
    // x0 results are accepted but never stored.
    push_c    = (grant_alu_c || grant_ld_c) && (wr_dest_c != 5'd0);

    wb.reg_addr_valid_pyro = out_valid_c;
    wb.reg_data_valid_pyro = out_valid_c;
    wb.reg_addr_pyro       = out_valid_c ? {59'd0, dest_mem[rd_ptr]} : 64'd0;
    wb.reg_data_pyro       = out_valid_c ? data_mem[rd_ptr] : 64'd0;
  end

  // Control state: pointers, occupancy, arbitration priority, retire counter.
  always_ff @(posedge clk) begin
    if (!reset_pyri) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr         <= 1'b0;
      retire_cnt <= '0;
    end else begin
      rr <= rr_next_c;
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_BW'(1);
        2'b01:   count <= count - CNT_BW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      dest_mem[wr_ptr] <= wr_dest_c;
      data_mem[wr_ptr] <= wr_data_c;
    end
  end

  assign retire_cnt_pyro = retire_cnt;
  assign fifo_full_pyro  = (count == CNT_BW'(DEPTH));

endmodule

// File: tb/tb_pyrm_writeback_block.sv
// Bench for pyrm_writeback_block: per-cycle vector table with hand-derived retries and a
// scoreboard queue modelling the FIFO contents that the write stream must reproduce in order.
module tb_pyrm_writeback_block;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 32;

  typedef struct {
    string       name;
    bit          rst;
    bit          av;
    logic [4:0]  ad;
    logic [63:0] adat;
    bit          lv;
    logic [4:0]  ldst;
    logic [63:0] ldat;
    bit          rar;
    bit          rdr;
    bit          ear;
    bit          elr;
  } vec_t;

  typedef struct {
    logic [4:0]  dest;
    logic [63:0] data;
  } exp_t;

  logic             clk;
  logic             reset_pyri;
  logic [CNT_W-1:0] retire_cnt_pyro;
  logic             fifo_full_pyro;

  pyrm_writeback_block_if wb ();

  pyrm_writeback_block #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_pyri      (reset_pyri),
    .wb              (wb.slave),
    .retire_cnt_pyro (retire_cnt_pyro),
    .fifo_full_pyro  (fifo_full_pyro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [31:0] exp_retire = '0;
  vec_t        tbl[$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input bit rst,
                              input bit av, input logic [4:0] ad, input logic [63:0] adat,
                              input bit lv, input logic [4:0] ldst, input logic [63:0] ldat,
                              input bit rar, input bit rdr, input bit ear, input bit elr);
    vec_t v;
    v.name = name; v.rst = rst;
    v.av = av; v.ad = ad; v.adat = adat;
    v.lv = lv; v.ldst = ldst; v.ldat = ldat;
    v.rar = rar; v.rdr = rdr; v.ear = ear; v.elr = elr;
    return v;
  endfunction

  function automatic vec_t idle(input string name);
    return mk(name, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // One cycle: drive, compare registered outputs against the scoreboard, compare retries, update model.
  task automatic apply(input vec_t v);
    exp_t e;
    bit   exp_valid;
    @(negedge clk);
    reset_pyri             = v.rst;
    wb.alu_valid_pyri      = v.av;
    wb.alu_dest_pyri       = v.ad;
    wb.alu_data_pyri       = v.adat;
    wb.ld_valid_pyri       = v.lv;
    wb.ld_dest_pyri        = v.ldst;
    wb.ld_data_pyri        = v.ldat;
    wb.reg_addr_retry_pyri = v.rar;
    wb.reg_data_retry_pyri = v.rdr;
    #1;
    exp_valid = v.rst && (sb.size() != 0);
    chk(wb.reg_addr_valid_pyro == exp_valid, {v.name, " addr_valid"}, 64'(wb.reg_addr_valid_pyro), 64'(exp_valid));
    chk(wb.reg_data_valid_pyro == exp_valid, {v.name, " data_valid"}, 64'(wb.reg_data_valid_pyro), 64'(exp_valid));
    chk(fifo_full_pyro == (sb.size() == DEPTH), {v.name, " fifo_full"}, 64'(fifo_full_pyro), 64'(sb.size() == DEPTH));
    chk(retire_cnt_pyro == exp_retire, {v.name, " retire_cnt"}, 64'(retire_cnt_pyro), 64'(exp_retire));
    if (exp_valid) begin
      e = sb[0];
      chk(wb.reg_addr_pyro == {59'd0, e.dest}, {v.name, " reg_addr"}, wb.reg_addr_pyro, {59'd0, e.dest});
      chk(wb.reg_data_pyro == e.data, {v.name, " reg_data"}, wb.reg_data_pyro, e.data);
    end else if (sb.size() == 0) begin
      chk(wb.reg_addr_pyro == 64'd0, {v.name, " idle reg_addr"}, wb.reg_addr_pyro, 64'd0);
      chk(wb.reg_data_pyro == 64'd0, {v.name, " idle reg_data"}, wb.reg_data_pyro, 64'd0);
    end
    chk(wb.alu_retry_pyro == v.ear, {v.name, " alu_retry"}, 64'(wb.alu_retry_pyro), 64'(v.ear));
    chk(wb.ld_retry_pyro == v.elr, {v.name, " ld_retry"}, 64'(wb.ld_retry_pyro), 64'(v.elr));

    if (!v.rst) begin
      sb.delete();
      exp_retire = '0;
    end else begin
      if (sb.size() != 0 && !v.rar && !v.rdr) begin
        void'(sb.pop_front());
        exp_retire = exp_retire + 32'd1;
      end
      if (v.av && !v.ear && v.ad != 5'd0) begin
        e.dest = v.ad; e.data = v.adat; sb.push_back(e);
      end
      if (v.lv && !v.elr && v.ldst != 5'd0) begin
        e.dest = v.ldst; e.data = v.ldat; sb.push_back(e);
      end
    end
  endtask

  initial begin
    reset_pyri             = 1'b0;
    wb.alu_valid_pyri      = 1'b0;
    wb.alu_dest_pyri       = '0;
    wb.alu_data_pyri       = '0;
    wb.ld_valid_pyri       = 1'b0;
    wb.ld_dest_pyri        = '0;
    wb.ld_data_pyri        = '0;
    wb.reg_addr_retry_pyri = 1'b0;
    wb.reg_data_retry_pyri = 1'b0;

    // Reset idle, then a single ALU write through the stage.
    tbl.push_back(idle("p1_idle"));
    tbl.push_back(mk("p2_alu", 1, 1, 5'd5, 64'hDEAD, 0, 5'd0, 64'd0, 0, 0, 0, 0));
    tbl.push_back(idle("p2_show"));
    tbl.push_back(idle("p2_after"));
    // Both channels contending: alternating grants.
    tbl.push_back(mk("p3_a", 1, 1, 5'd1, 64'h101, 1, 5'd11, 64'h111, 0, 0, 0, 1));
    tbl.push_back(mk("p3_b", 1, 1, 5'd2, 64'h102, 1, 5'd11, 64'h111, 0, 0, 1, 0));
    tbl.push_back(mk("p3_c", 1, 1, 5'd2, 64'h102, 1, 5'd12, 64'h112, 0, 0, 0, 1));
    tbl.push_back(mk("p3_d", 1, 1, 5'd3, 64'h103, 1, 5'd12, 64'h112, 0, 0, 1, 0));
    tbl.push_back(mk("p3_e", 1, 1, 5'd3, 64'h103, 1, 5'd13, 64'h113, 0, 0, 0, 1));
    tbl.push_back(mk("p3_f", 1, 1, 5'd4, 64'h104, 1, 5'd13, 64'h113, 0, 0, 1, 0));
    tbl.push_back(mk("p3_g", 1, 1, 5'd4, 64'h104, 1, 5'd14, 64'h114, 0, 0, 0, 1));
    tbl.push_back(mk("p3_h", 1, 0, 5'd0, 64'd0,   1, 5'd14, 64'h114, 0, 0, 0, 0));
    tbl.push_back(idle("p3_drain0"));
    tbl.push_back(idle("p3_drain1"));
    // Fill under data-channel stall, then push+pop while full.
    tbl.push_back(mk("p4_fill1", 1, 1, 5'd21, 64'h221, 0, 5'd0, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("p4_fill2", 1, 1, 5'd22, 64'h222, 0, 5'd0, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("p4_fill3", 1, 1, 5'd23, 64'h223, 0, 5'd0, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("p4_fill4", 1, 1, 5'd24, 64'h224, 0, 5'd0, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("p4_full",  1, 1, 5'd25, 64'h225, 0, 5'd0, 64'd0, 0, 1, 1, 1));
    tbl.push_back(mk("p4_swap",  1, 1, 5'd25, 64'h225, 0, 5'd0, 64'd0, 0, 0, 0, 0));
    tbl.push_back(mk("p4_astall", 1, 0, 5'd0, 64'd0, 1, 5'd9, 64'h99, 1, 0, 1, 1));
    for (int i = 0; i < 6; i++) tbl.push_back(idle("p4_drain"));
    // x0 write absorbed, following load appears next.
    tbl.push_back(mk("p5_x0", 1, 1, 5'd0, 64'h55, 0, 5'd0, 64'd0, 0, 0, 0, 0));
    tbl.push_back(mk("p5_ld", 1, 0, 5'd0, 64'd0, 1, 5'd7, 64'h77, 0, 0, 0, 0));
    tbl.push_back(idle("p5_drain0"));
    tbl.push_back(idle("p5_drain1"));
    // Mid-operation reset discards queued entries.
    tbl.push_back(mk("p6_q1", 1, 1, 5'd31, 64'h331, 0, 5'd0, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("p6_q2", 1, 1, 5'd30, 64'h330, 0, 5'd0, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("p6_q3", 1, 1, 5'd29, 64'h329, 0, 5'd0, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("p6_rst", 0, 1, 5'd28, 64'h328, 1, 5'd27, 64'h327, 0, 1, 1, 1));
    tbl.push_back(idle("p6_post0"));
    tbl.push_back(idle("p6_post1"));
    // Priority after reset is ALU; an x0 grant still rotates priority.
    tbl.push_back(mk("p7_r1", 1, 1, 5'd20, 64'h440, 1, 5'd19, 64'h441, 0, 0, 0, 1));
    tbl.push_back(mk("p7_r2", 1, 0, 5'd0,  64'd0,   1, 5'd19, 64'h441, 0, 0, 0, 0));
    tbl.push_back(mk("p7_r3", 1, 1, 5'd0,  64'h55,  1, 5'd15, 64'h515, 0, 0, 1, 0));
    tbl.push_back(mk("p7_r4", 1, 1, 5'd0,  64'h55,  1, 5'd16, 64'h516, 0, 0, 0, 1));
    tbl.push_back(mk("p7_r5", 1, 1, 5'd17, 64'h517, 1, 5'd16, 64'h516, 0, 0, 1, 0));
    tbl.push_back(mk("p7_r6", 1, 1, 5'd17, 64'h517, 0, 5'd0,  64'd0,   0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(idle("p7_drain"));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) apply(tbl[i]);

    chk(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
